// File: rtl/shadow_lsu_arbiter.sv
// shadow_lsu_arbiter: shares the single LSU issue port between the issue stage and the shadow-register save engine
//   issue_*_i / issue_ready_o : issue-stage load/store request and its grant
//   shru_*_i / shru_ready_o   : save-engine stack store, burst flag, commit pulse and grant
//   lsu_*                     : muxed request towards the LSU and source select
//   outstanding_o             : uncommitted shadow stores
//   underflow_o               : sticky, commit pulse seen with nothing outstanding
module shadow_lsu_arbiter #(
  parameter type fu_data_t = logic,
  parameter int unsigned XLEN = 64,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned MAX_SHRU_STREAK = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 issue_valid_i,
  input  fu_data_t                             issue_fu_data_i,
  input  logic                                 issue_is_load_i,
  input  logic [XLEN-1:0]                      issue_addr_i,
  output logic                                 issue_ready_o,
  input  logic                                 shru_valid_i,
  input  fu_data_t                             shru_fu_data_i,
  input  logic [XLEN-1:0]                      shru_addr_i,
  input  logic                                 shru_burst_i,
  output logic                                 shru_ready_o,
  input  logic                                 shru_store_done_i,
  input  logic                                 lsu_ready_i,
  output logic                                 lsu_valid_o,
  output fu_data_t                             lsu_fu_data_o,
  output logic                                 lsu_sel_shru_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 underflow_o
);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned SW = $clog2(MAX_SHRU_STREAK+1);
  logic [CW-1:0] out_q, out_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [XLEN-1:0] lo_q, lo_d, hi_q, hi_d;
  logic uf_q, uf_d;
  logic hazard, sh_el, is_el, sh_win, is_win, sh_xfer, is_xfer, fresh, done;
  always_comb begin
    done = shru_store_done_i;
    // a load anywhere inside the stack words being saved must wait for the commits
    hazard = issue_is_load_i && out_q != '0 && issue_addr_i >= lo_q &&
             issue_addr_i <= hi_q + XLEN'(XLEN/8 - 1);
    sh_el = shru_valid_i && out_q < CW'(MAX_OUTSTANDING);
    is_el = issue_valid_i && !hazard;
    sh_win = sh_el && (shru_burst_i || !is_el || streak_q != SW'(MAX_SHRU_STREAK));
    is_win = is_el && !sh_win;
    sh_xfer = sh_win && lsu_ready_i;
    is_xfer = is_win && lsu_ready_i;
    // window restarts when this store becomes the only uncommitted one
    fresh = out_q == '0 || (out_q == CW'(1) && done);
    lo_d = !sh_xfer ? lo_q : (fresh || shru_addr_i < lo_q) ? shru_addr_i : lo_q;
    hi_d = !sh_xfer ? hi_q : (fresh || shru_addr_i > hi_q) ? shru_addr_i : hi_q;
    out_d = (sh_xfer && !done) ? out_q + CW'(1) :
            (!sh_xfer && done && out_q != '0) ? out_q - CW'(1) : out_q;
    uf_d = uf_q || (done && out_q == '0);
    streak_d = !lsu_ready_i ? streak_q :
               (!is_el || is_xfer) ? '0 :
               (sh_xfer && streak_q != SW'(MAX_SHRU_STREAK)) ? streak_q + SW'(1) : streak_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q <= '0;
      streak_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      uf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      streak_q <= streak_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      uf_q <= uf_d;
    end
  end
  assign lsu_valid_o = (sh_win || is_win) && !rst_i;
  assign lsu_sel_shru_o = sh_win;
  assign lsu_fu_data_o = is_win ? issue_fu_data_i : shru_fu_data_i;
  assign shru_ready_o = sh_xfer && !rst_i;
  assign issue_ready_o = is_xfer && !rst_i;
  assign outstanding_o = out_q;
  assign underflow_o = uf_q;
endmodule

// File: tb/tb_shadow_lsu_arbiter.sv
// tb_shadow_lsu_arbiter: directed stimulus with a queue-based reference model checked every cycle
module tb_shadow_lsu_arbiter;
  typedef logic [15:0] fd_t;
  localparam int MO = 4;
  localparam int MS = 4;
  logic clk_i = 1'b0;
  logic rst_i;
  logic issue_valid_i, issue_is_load_i, issue_ready_o;
  fd_t issue_fu_data_i, shru_fu_data_i, lsu_fu_data_o;
  logic [63:0] issue_addr_i, shru_addr_i;
  logic shru_valid_i, shru_burst_i, shru_ready_o, shru_store_done_i;
  logic lsu_ready_i, lsu_valid_o, lsu_sel_shru_o, underflow_o;
  logic [2:0] outstanding_o;
  int cmp = 0;
  int mis = 0;
  int m_out = 0;
  int m_streak = 0;
  bit m_uf = 0;
  logic [63:0] win [$];
  bit pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  shadow_lsu_arbiter #(.fu_data_t(fd_t), .XLEN(64), .MAX_OUTSTANDING(MO), .MAX_SHRU_STREAK(MS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_fu_data_i(issue_fu_data_i), .issue_is_load_i(issue_is_load_i),
    .issue_addr_i(issue_addr_i), .issue_ready_o(issue_ready_o),
    .shru_valid_i(shru_valid_i), .shru_fu_data_i(shru_fu_data_i), .shru_addr_i(shru_addr_i),
    .shru_burst_i(shru_burst_i), .shru_ready_o(shru_ready_o), .shru_store_done_i(shru_store_done_i),
    .lsu_ready_i(lsu_ready_i), .lsu_valid_o(lsu_valid_o), .lsu_fu_data_o(lsu_fu_data_o),
    .lsu_sel_shru_o(lsu_sel_shru_o), .outstanding_o(outstanding_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // winner selection from the current model state and inputs
  function automatic void model(output bit sw, output bit iw, output bit iel);
    logic [63:0] lo, hi;
    bit haz, sel;
    lo = '1;
    hi = '0;
    foreach (win[i]) begin
      if (win[i] < lo) lo = win[i];
      if (win[i] > hi) hi = win[i];
    end
    haz = issue_is_load_i && m_out != 0 && issue_addr_i >= lo && issue_addr_i <= hi + 64'd7;
    iel = issue_valid_i && !haz;
    sel = shru_valid_i && m_out < MO;
    sw = sel && (shru_burst_i || !iel || m_streak < MS);
    iw = iel && !sw;
  endfunction

  initial forever begin
    bit sw, iw, iel, sx, dn;
    @(posedge clk_i or posedge rst_i);
    if (rst_i) begin
      m_out = 0;
      m_streak = 0;
      m_uf = 0;
      win.delete();
    end else begin
      model(sw, iw, iel);
      sx = sw && lsu_ready_i;
      dn = shru_store_done_i;
      if (lsu_ready_i) begin
        if (!iel || iw) m_streak = 0;
        else if (sw && m_streak < MS) m_streak++;
      end
      if (sx) begin
        if (m_out == 0 || (m_out == 1 && dn)) win.delete();
        win.push_back(shru_addr_i);
      end
      if (dn && m_out == 0) m_uf = 1;
      if (sx && !dn) m_out++;
      else if (!sx && dn && m_out > 0) m_out--;
    end
  end

  initial forever begin
    bit sw, iw, iel;
    @(negedge clk_i);
    model(sw, iw, iel);
    chk("m_lsu_valid", lsu_valid_o, !rst_i && (sw || iw));
    chk("m_sel", lsu_sel_shru_o, sw);
    chk("m_shru_ready", shru_ready_o, !rst_i && sw && lsu_ready_i);
    chk("m_issue_ready", issue_ready_o, !rst_i && iw && lsu_ready_i);
    chk("m_data", lsu_fu_data_o, iw ? issue_fu_data_i : shru_fu_data_i);
    chk("m_outstanding", outstanding_o, m_out);
    chk("m_underflow", underflow_o, m_uf);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 0;
    issue_is_load_i = 0;
    issue_addr_i = 64'h4000;
    issue_fu_data_i = 16'hA000;
    shru_valid_i = 0;
    shru_addr_i = 64'h0;
    shru_fu_data_i = 16'h5000;
    shru_burst_i = 0;
    shru_store_done_i = 0;
  endtask

  initial begin
    rst_i = 1;
    idle();
    lsu_ready_i = 1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    #2 chk("rst_out", outstanding_o, 0);
    chk("rst_uf", underflow_o, 0);
    chk("rst_valid", lsu_valid_o, 0);
    // burst: shadow wins three times in a row over a pending store
    step();
    shru_burst_i = 1;
    issue_valid_i = 1;
    issue_fu_data_i = 16'hA001;
    shru_valid_i = 1;
    shru_fu_data_i = 16'h5001;
    shru_addr_i = 64'h1000;
    #2 chk("burst_s0", shru_ready_o, 1);
    chk("burst_i0", issue_ready_o, 0);
    chk("burst_data", lsu_fu_data_o, 16'h5001);
    step();
    shru_addr_i = 64'hFF8;
    #2 chk("burst_s1", shru_ready_o, 1);
    chk("burst_i1", issue_ready_o, 0);
    step();
    shru_addr_i = 64'hFF0;
    #2 chk("burst_s2", shru_ready_o, 1);
    step();
    shru_valid_i = 0;
    #2 chk("burst_out3", outstanding_o, 3);
    chk("burst_issue", issue_ready_o, 1);
    chk("burst_idata", lsu_fu_data_o, 16'hA001);
    step();
    idle();
    shru_store_done_i = 1;
    repeat (3) step();
    shru_store_done_i = 0;
    #2 chk("drain_out", outstanding_o, 0);
    // hazard window 0xFF0..0xFFF
    shru_valid_i = 1;
    shru_addr_i = 64'hFF8;
    step();
    shru_addr_i = 64'hFF0;
    step();
    shru_valid_i = 0;
    issue_valid_i = 1;
    issue_is_load_i = 1;
    issue_addr_i = 64'hFFC;
    #2 chk("haz_out2", outstanding_o, 2);
    chk("haz_ffc", issue_ready_o, 0);
    chk("haz_valid", lsu_valid_o, 0);
    step();
    issue_addr_i = 64'hFFF;
    #2 chk("haz_fff", issue_ready_o, 0);
    step();
    issue_addr_i = 64'hFEF;
    #2 chk("haz_fef", issue_ready_o, 1);
    step();
    issue_addr_i = 64'h1000;
    #2 chk("haz_1000", issue_ready_o, 1);
    step();
    issue_valid_i = 0;
    shru_store_done_i = 1;
    repeat (2) step();
    shru_store_done_i = 0;
    issue_valid_i = 1;
    issue_addr_i = 64'hFFC;
    #2 chk("haz_clear", issue_ready_o, 1);
    chk("haz_out0", outstanding_o, 0);
    // fairness: S,S,S,S,I repeating
    step();
    idle();
    issue_valid_i = 1;
    shru_valid_i = 1;
    shru_addr_i = 64'h800;
    for (int c = 0; c < 10; c++) begin
      shru_store_done_i = (c != 0 && c != 5);
      #2 chk("fair_sel", lsu_sel_shru_o, pat[c]);
      chk("fair_iss", issue_ready_o, !pat[c]);
      step();
    end
    idle();
    #2 chk("fair_out", outstanding_o, 0);
    // credit limit
    shru_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      shru_addr_i = 64'h2000 - 64'(8 * i);
      #2 chk("credit_grant", shru_ready_o, 1);
      step();
    end
    #2 chk("credit_5th", shru_ready_o, 0);
    chk("credit_out4", outstanding_o, 4);
    chk("credit_valid", lsu_valid_o, 0);
    shru_valid_i = 0;
    shru_store_done_i = 1;
    step();
    shru_valid_i = 1;
    #2 chk("credit_out3", outstanding_o, 3);
    chk("credit_same_rdy", shru_ready_o, 1);
    step();
    shru_valid_i = 0;
    shru_store_done_i = 0;
    #2 chk("credit_same", outstanding_o, 3);
    shru_store_done_i = 1;
    repeat (3) step();
    shru_store_done_i = 0;
    #2 chk("credit_drain", outstanding_o, 0);
    // underflow is sticky
    shru_store_done_i = 1;
    step();
    shru_store_done_i = 0;
    #2 chk("uf_set", underflow_o, 1);
    chk("uf_out", outstanding_o, 0);
    repeat (2) step();
    #2 chk("uf_sticky", underflow_o, 1);
    // LSU stalled
    issue_valid_i = 1;
    shru_valid_i = 1;
    shru_fu_data_i = 16'h5077;
    lsu_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      #2 chk("stall_srdy", shru_ready_o, 0);
      chk("stall_irdy", issue_ready_o, 0);
      chk("stall_valid", lsu_valid_o, 1);
      chk("stall_sel", lsu_sel_shru_o, 1);
      chk("stall_data", lsu_fu_data_o, 16'h5077);
      chk("stall_out", outstanding_o, 0);
      step();
    end
    lsu_ready_i = 1;
    idle();
    // reset in the middle of a burst
    shru_burst_i = 1;
    shru_valid_i = 1;
    issue_valid_i = 1;
    shru_addr_i = 64'h1000;
    step();
    shru_addr_i = 64'hFF8;
    step();
    #1 rst_i = 1;
    #1 chk("rst_mid_valid", lsu_valid_o, 0);
    chk("rst_mid_srdy", shru_ready_o, 0);
    chk("rst_mid_irdy", issue_ready_o, 0);
    chk("rst_mid_out", outstanding_o, 0);
    chk("rst_mid_uf", underflow_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 0;
    idle();
    #2 chk("rst_rel_out", outstanding_o, 0);
    shru_valid_i = 1;
    shru_addr_i = 64'h3000;
    #1 chk("rst_rel_grant", shru_ready_o, 1);
    step();
    idle();
    #2 chk("rst_rel_out1", outstanding_o, 1);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule

// File: doc/shadow_lsu_arbiter.md
Name: shadow_lsu_arbiter

Overview:
- Shares the single LSU issue port between the issue stage (normal loads and stores) and the shadow-register save engine, which emits SHSR stack stores.
- Sits in EX, between the issue/dispatch path and the LSU input.
- Tracks uncommitted shadow stores and stalls issue-stage loads that hit the stack window being written, so loads cannot read stale stack data.
- Guarantees the issue stage a slot after a bounded streak of shadow grants outside an interrupt-entry burst.

Parameters:
- fu_data_t, logic: FU data struct type, passed through unchanged.
- XLEN, 64: address width and stack word width; stack word = XLEN/8 bytes.
- MAX_OUTSTANDING, 4: maximum uncommitted shadow stores (≥1).
- MAX_SHRU_STREAK, 4: consecutive non-burst shadow grants allowed while issue is eligible (≥1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- issue_valid_i  in  1  issue stage presents an LSU instruction.
- issue_fu_data_i  in  fu_data_t  issue-stage FU data.
- issue_is_load_i  in  1  issue request is a load.
- issue_addr_i  in  XLEN  effective byte address of the issue request.
- issue_ready_o  out  1  issue request granted this cycle.
- shru_valid_i  in  1  save engine presents a shadow store.
- shru_fu_data_i  in  fu_data_t  shadow store FU data.
- shru_addr_i  in  XLEN  stack address of the shadow store.
- shru_burst_i  in  1  interrupt-entry save sequence active.
- shru_ready_o  out  1  shadow store granted this cycle.
- shru_store_done_i  in  1  pulse: one shadow store committed.
- lsu_ready_i  in  1  LSU accepts an instruction.
- lsu_valid_o  out  1  instruction presented to the LSU.
- lsu_fu_data_o  out  fu_data_t  muxed FU data.
- lsu_sel_shru_o  out  1  current LSU request comes from the save engine.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  uncommitted shadow stores.
- underflow_o  out  1  sticky: done pulse received with zero outstanding.

Behaviour:
- Grant path is combinational: 0-cycle latency from valid to LSU.
- A transfer occurs when lsu_valid_o && lsu_ready_i.
- Shadow eligible: shru_valid_i && outstanding < MAX_OUTSTANDING. A done pulse in the same cycle does not free a slot (no bypass).
- Issue eligible: issue_valid_i && !hazard.
- hazard = issue_is_load_i && outstanding != 0 && win_lo <= issue_addr_i <= win_hi + XLEN/8 - 1. Unsigned compare over the full XLEN; no wrap handling.
- Priority rules:
  - shru_burst_i=1: shadow always wins when eligible.
  - Otherwise shadow wins unless streak == MAX_SHRU_STREAK and issue is eligible; then issue wins.
  - If only one side is eligible, that side wins.
- Outputs:
  - lsu_valid_o = winner exists.
  - lsu_sel_shru_o = shadow is the winner.
  - lsu_fu_data_o = the winner's data, or shru_fu_data_i when there is no winner.
  - shru_ready_o = shadow wins && lsu_ready_i.
  - issue_ready_o = issue wins && lsu_ready_i.
- streak counter:
  - +1, saturating at MAX_SHRU_STREAK, on a shadow transfer while issue is eligible.
  - Cleared on an issue transfer, or in any cycle where issue is not eligible.
  - Unchanged in all other cycles.
- outstanding counter:
  - +1 on a shadow transfer; -1 on shru_store_done_i.
  - Both in the same cycle: unchanged.
  - Done at 0: counter stays 0 and underflow_o sets; underflow_o clears only on reset.
- Stack window:
  - Shadow transfer with outstanding == 0, or with outstanding == 1 and a same-cycle done: win_lo = win_hi = shru_addr_i.
  - Otherwise a shadow transfer extends the window: win_lo = min(win_lo, addr), win_hi = max(win_hi, addr).
  - The window is meaningless once outstanding reaches 0.
- Reset (async, any cycle, including mid-burst):
  - Counters, window and underflow cleared.
  - While rst_i is high, lsu_valid_o, issue_ready_o and shru_ready_o are forced to 0.
  - In-flight done pulses after reset count toward underflow; the controlling block must reset together with this block.
- lsu_ready_i=0: no state changes except done handling.
- Valid inputs need not be held: the arbiter is stateless with respect to requests.

Test Plan:
- Burst: shru_burst_i=1; shadow stores at addresses 0x1000, 0xFF8, 0xFF0; issue_valid_i=1 (store) throughout → 3 consecutive shadow grants, no issue grant until shru_valid_i drops; outstanding_o reaches 3.
- Hazard: window 0xFF0–0xFF8, outstanding=2. Issue load at 0xFFC → issue_ready_o=0. Issue load at 0x1000 → granted. Two done pulses → a load at 0xFFC is granted the next cycle.
- Fairness: burst=0; shadow and issue both valid continuously; MAX_SHRU_STREAK=4 → grant pattern S,S,S,S,I,S,S,S,S,I.
- Credit limit: MAX_OUTSTANDING=4, no done pulses → the 5th shadow request sees shru_ready_o=0. Grant and done in the same cycle at count 3 → count stays 3.
- Underflow and reset: done pulse at outstanding=0 → underflow_o=1 and stays 1. Assert rst_i mid-burst with outstanding=2 → all outputs 0 immediately; outstanding_o=0 after release.
- lsu_ready_i=0 for 3 cycles with both sides valid → no readies, counters frozen, lsu_valid_o=1 with shadow data selected.
